slave_to_master: RTL

- Slave-side I2C byte transmitter for master read transfers.
- Loads a parallel byte, serialises it LSB-first onto the open-drain SDA line, then releases SDA for the master's ACK/NACK and reports the result.
- Clocked directly by the bus SCL; bit order matches the slave receive shift register so the two paths are symmetric.
- Sits beside the slave receive path; the slave controller drives load/data_in after an address match with R/W=1.

---
 rtl/slave_to_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/slave_to_master.sv
`default_nettype none
// ============================================================================
// Module   : slave_to_master
// Purpose  : Slave-side I2C byte transmitter for master read transfers.
//            A byte is loaded in parallel and shifted out LSB-first on the
//            open-drain SDA line. SDA is then released so the master can
//            ACK or NACK, and the result is reported. The module is clocked
//            directly by the bus SCL.
// Ports    : SCL     - bus clock (drive on negedge, ACK sample on posedge)
//            RST     - asynchronous active-low reset
//            load    - request to transmit data_in (sampled on negedge SCL)
//            data_in - byte to transmit, captured when load is accepted
//            SDA     - open-drain data line, driven 0 or released (Z)
//            busy    - high from load acceptance until return to idle
//            done    - one-SCL-period pulse at the end of each ACK slot
//            ack_ok  - last byte was ACKed by the master
//            nack    - last byte was NACKed (held until next accepted load)
// Revision : 1.0 - initial release
// ============================================================================
module slave_to_master #(
    parameter int DATA_W = 8
) (
    input  logic              SCL,
    input  logic              RST,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    inout  wire               SDA,
    output logic              busy,
    output logic              done,
    output logic              ack_ok,
    output logic              nack
);

    localparam int                CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_shift_reg;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_sda_low;
    logic              r_busy;
    logic              r_done;
    logic              r_ack_ok;
    logic              r_nack;
    logic              r_ack_smp;

    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_sda_low_nxt;
    logic              w_busy_nxt;
    logic              w_ack_ok_nxt;
    logic              w_nack_nxt;
    logic [DATA_W-1:0] w_shift_dn;

    // Open-drain: only ever pull low or let go. Because r_sda_low changes
    // only on negedge SCL (or async reset), SDA never moves while SCL is high.
    assign SDA = r_sda_low ? 1'b0 : 1'bz;

    assign busy   = r_busy;
    assign done   = r_done;
    assign ack_ok = r_ack_ok;
    assign nack   = r_nack;

    // Shifted copy of the register; its LSB is the next bit to present.
    assign w_shift_dn = r_shift_reg >> 1;

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift_reg;
        w_cnt_nxt     = r_bit_cnt;
        w_sda_low_nxt = r_sda_low;
        w_busy_nxt    = r_busy;
        w_ack_ok_nxt  = r_ack_ok;
        w_nack_nxt    = r_nack;

        case (r_state)
            S_IDLE: begin
                w_sda_low_nxt = 1'b0;
                if (load) begin
                    w_shift_nxt   = data_in;
                    w_cnt_nxt     = '0;
                    w_sda_low_nxt = ~data_in[0];
                    w_busy_nxt    = 1'b1;
                    w_ack_ok_nxt  = 1'b0;
                    w_nack_nxt    = 1'b0;
                    w_state_nxt   = S_SEND;
                end
            end

            S_SEND: begin
                if (r_bit_cnt == C_LAST) begin
                    // Last bit has been sampled; free the line for the ACK.
                    w_sda_low_nxt = 1'b0;
                    w_state_nxt   = S_ACK;
                end else begin
                    w_shift_nxt   = w_shift_dn;
                    w_sda_low_nxt = ~w_shift_dn[0];
                    w_cnt_nxt     = r_bit_cnt + CNT_W'(1);
                end
            end

            S_ACK: begin
                w_ack_ok_nxt = r_ack_smp;
                w_nack_nxt   = ~r_ack_smp;
                if (r_ack_smp && load) begin
                    // Back-to-back byte: reload without dropping busy. The
                    // just-reported ACK result is kept visible.
                    w_shift_nxt   = data_in;
                    w_cnt_nxt     = '0;
                    w_sda_low_nxt = ~data_in[0];
                    w_state_nxt   = S_SEND;
                end else begin
                    w_busy_nxt    = 1'b0;
                    w_sda_low_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end

            default: begin
                w_sda_low_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

    always_ff @(negedge SCL or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
            r_sda_low   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ack_ok    <= 1'b0;
            r_nack      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift_reg <= w_shift_nxt;
            r_bit_cnt   <= w_cnt_nxt;
            r_sda_low   <= w_sda_low_nxt;
            r_busy      <= w_busy_nxt;
            // done pulses for exactly the SCL period that follows the ACK slot
            r_done      <= (r_state == S_ACK);
            r_ack_ok    <= w_ack_ok_nxt;
            r_nack      <= w_nack_nxt;
        end
    end

    // The master drives its ACK/NACK while SCL is low; it is stable and
    // captured on the rising edge inside the ACK slot.
    always_ff @(posedge SCL or negedge RST) begin
        if (!RST) begin
            r_ack_smp <= 1'b0;
        end else if (r_state == S_ACK) begin
            r_ack_smp <= ~SDA;
        end
    end

endmodule
`default_nettype wire
